// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared register map, reset constants, bus FSM states and byte-merge helper for clint
//
// Contents:
//   *Offset        byte offsets of the six mapped registers
//   MtimecmpReset  reset value of mtimecmp (all ones, so no timer interrupt after reset)
//   bus_state_e    Wishbone slave FSM states
//   byte_merge     per-byte-enable merge of write data over a register word
package clint_pkg;

    localparam logic [4:0] MsipOffset       = 5'h00;
    localparam logic [4:0] SsipOffset       = 5'h04;
    localparam logic [4:0] MtimecmpLoOffset = 5'h08;
    localparam logic [4:0] MtimecmpHiOffset = 5'h0C;
    localparam logic [4:0] MtimeLoOffset    = 5'h10;
    localparam logic [4:0] MtimeHiOffset    = 5'h14;

    localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        Idle = 1'b0,
        Ack  = 1'b1
    } bus_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_if.sv
// rtl/clint_if.sv - Wishbone-classic 32-bit bus bundle between the data-memory master and clint
//
// Signals:
//   wb_cyc, wb_stb  request is cyc & stb
//   wb_we           1 = write, 0 = read
//   wb_addr[4:0]    byte offset, bits [1:0] ignored
//   wb_sel[3:0]     write byte enables
//   wb_dat_i[31:0]  write data (master -> slave)
//   wb_dat_o[31:0]  read data (slave -> master), valid while wb_ack
//   wb_ack          one-cycle acknowledge
interface clint_if;
    import clint_pkg::*;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_sel, wb_dat_i,
        output wb_dat_o, wb_ack
    );

endinterface

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - free-running 0..CLOCK_CYCLES-1 counter producing the mtime increment tick
//
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high; counter returns to 0
//   tick   high for the one cycle in which the counter sits at its terminal count
module clint_prescaler #(
    parameter int unsigned CLOCK_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    import clint_pkg::*;

    localparam int unsigned CW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
    localparam logic [CW-1:0] Terminal = CW'(CLOCK_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Tick is decoded from the registered count so mtime advances on the
    // same edge that wraps the counter; with CLOCK_CYCLES = 1 it is always high.
    always_comb begin
        tick    = (count_q == Terminal);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clint.sv
// rtl/clint.sv - core-local interruptor: mtime/mtimecmp and msip/ssip behind a Wishbone-classic slave
//
// Ports:
//   clock, reset     system clock; asynchronous active-high reset
//   bus              clint_if.slave, 32-bit Wishbone-classic, registered ack
//   mem_msip         machine software-interrupt pending
//   mem_ssip         supervisor software-interrupt pending
//   mem_mtime        current mtime
//   mem_mtimecmp     current mtimecmp
module clint
    import clint_pkg::*;
#(
    parameter int unsigned CLOCK_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    clint_if.slave      bus,
    output logic        mem_msip,
    output logic        mem_ssip,
    output logic [63:0] mem_mtime,
    output logic [63:0] mem_mtimecmp
);

    bus_state_e  state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        msip_q, msip_d;
    logic        ssip_q, ssip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;

    logic        tick;
    logic        req;
    logic        wr;
    logic [4:0]  word_addr;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    clint_prescaler #(
        .CLOCK_CYCLES(CLOCK_CYCLES)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign unused_addr_bits = ^bus.wb_addr[1:0];

    always_comb begin
        req       = bus.wb_cyc & bus.wb_stb;
        word_addr = {bus.wb_addr[4:2], 2'b00};
        // Requests are only taken in Idle; one held through Ack is sampled afresh.
        wr        = (state_q == Idle) & req & bus.wb_we;

        rdata = '0;
        case (word_addr)
            MsipOffset:       rdata = {31'b0, msip_q};
            SsipOffset:       rdata = {31'b0, ssip_q};
            MtimecmpLoOffset: rdata = mtimecmp_q[31:0];
            MtimecmpHiOffset: rdata = mtimecmp_q[63:32];
            MtimeLoOffset:    rdata = mtime_q[31:0];
            MtimeHiOffset:    rdata = mtime_q[63:32];
            default:          rdata = '0;
        endcase

        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            Idle: begin
                if (req) begin
                    state_d = Ack;
                    ack_d   = 1'b1;
                    dat_d   = bus.wb_we ? 32'h0 : rdata;
                end
            end
            Ack: begin
                state_d = Idle;
            end
            default: begin
                state_d = Idle;
            end
        endcase

        msip_d     = msip_q;
        ssip_d     = ssip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

        if (wr) begin
            case (word_addr)
                MsipOffset: if (bus.wb_sel[0]) msip_d = bus.wb_dat_i[0];
                SsipOffset: if (bus.wb_sel[0]) ssip_d = bus.wb_dat_i[0];
                MtimecmpLoOffset:
                    mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], bus.wb_dat_i, bus.wb_sel);
                MtimecmpHiOffset:
                    mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], bus.wb_dat_i, bus.wb_sel);
                // A write to either half overrides the increment entirely: the
                // other half keeps its old value, with no carry propagated into it.
                MtimeLoOffset:
                    mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], bus.wb_dat_i, bus.wb_sel)};
                MtimeHiOffset:
                    mtime_d = {byte_merge(mtime_q[63:32], bus.wb_dat_i, bus.wb_sel), mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= Idle;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            msip_q     <= 1'b0;
            ssip_q     <= 1'b0;
            mtimecmp_q <= MtimecmpReset;
            mtime_q    <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            msip_q     <= msip_d;
            ssip_q     <= ssip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
        end
    end

    assign bus.wb_ack   = ack_q;
    assign bus.wb_dat_o = dat_q;
    assign mem_msip     = msip_q;
    assign mem_ssip     = ssip_q;
    assign mem_mtime    = mtime_q;
    assign mem_mtimecmp = mtimecmp_q;

endmodule
